// File: rtl/fpga_test_sequencer.sv
// Sequences one run of the FPGA program engine: streams the input channel in, launches the engine,
// waits for finished under a watchdog, then reads back and compares every output word.
module fpga_test_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NIn                = 3,
  parameter int NOut               = 9,
  parameter int TimeoutCycles      = 1024,
  localparam int InAw  = (NIn > 1) ? $clog2(NIn) : 1,
  localparam int OutAw = (NOut > 1) ? $clog2(NOut) : 1,
  localparam int CntW  = $clog2(NOut + 1),
  localparam int CycW  = $clog2(TimeoutCycles + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          inValid,
  input  logic [MemoryElementWidth-1:0] inData,
  output logic                          inReady,
  input  logic                          expValid,
  input  logic [MemoryElementWidth-1:0] expData,
  output logic                          expReady,
  output logic                          run,
  input  logic                          finished,
  input  logic                          success,
  output logic                          loadEn,
  output logic [InAw-1:0]               loadAddr,
  output logic [MemoryElementWidth-1:0] loadData,
  output logic [OutAw-1:0]              outAddr,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [OutAw-1:0]              mismatchIndex,
  output logic [CntW-1:0]               mismatchCount
);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, ADDR, CMP, REPORT} stateT;

  stateT                state, stateNext;
  logic [InAw-1:0]      wordCount;
  logic [CycW-1:0]      cycleCount;
  logic [OutAw-1:0]     index;
  logic                 successReg;
  logic                 lastIn, lastOut, watchdogHit, wordDiffers;

  assign lastIn      = (wordCount == InAw'(NIn - 1));
  assign lastOut     = (index == OutAw'(NOut - 1));
  assign watchdogHit = (cycleCount == CycW'(TimeoutCycles - 1));
  assign wordDiffers = (outData != expData);

  assign inReady  = (state == LOAD);
  assign loadEn   = inReady && inValid;
  assign loadAddr = loadEn ? wordCount : '0;
  assign loadData = loadEn ? inData : '0;
  assign run      = (state == LAUNCH);
  assign expReady = (state == CMP);
  assign outAddr  = (state == ADDR || state == CMP) ? index : '0;
  assign busy     = (state != IDLE) && (state != REPORT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // finished takes priority over the watchdog when both land in the same cycle
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = LOAD;
      LOAD:    if (inValid && lastIn) stateNext = LAUNCH;
      LAUNCH:  stateNext = WAIT;
      WAIT: begin
        if (finished)         stateNext = ADDR;
        else if (watchdogHit) stateNext = REPORT;
      end
      ADDR:    stateNext = CMP;
      CMP:     if (expValid) stateNext = lastOut ? REPORT : ADDR;
      REPORT:  if (start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wordCount     <= '0;
      cycleCount    <= '0;
      index         <= '0;
      successReg    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      mismatchIndex <= '0;
      mismatchCount <= '0;
    end else begin
      case (state)
        IDLE, REPORT: begin
          if (start) begin
            wordCount     <= '0;
            cycleCount    <= '0;
            index         <= '0;
            successReg    <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            mismatchIndex <= '0;
            mismatchCount <= '0;
          end
        end
        LOAD: begin
          if (inValid && !lastIn) wordCount <= wordCount + InAw'(1);
        end
        WAIT: begin
          cycleCount <= cycleCount + CycW'(1);
          if (finished) begin
            successReg <= success;
            index      <= '0;
          end else if (watchdogHit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
          end
        end
        CMP: begin
          if (expValid) begin
            if (wordDiffers) begin
              if (mismatchCount == '0) mismatchIndex <= index;
              if (mismatchCount != CntW'(NOut)) mismatchCount <= mismatchCount + CntW'(1);
            end
            // pass must account for the word being compared this cycle
            if (lastOut) begin
              done <= 1'b1;
              pass <= successReg && (mismatchCount == '0) && !wordDiffers;
            end else begin
              index <= index + OutAw'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_test_sequencer.sv
// Scoreboard bench for fpga_test_sequencer: directed runs against a small engine model,
// results queued at issue time and checked by an independent monitor.
module tb_fpga_test_sequencer;

  localparam int W  = 12;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, inValid, inReady, expValid, expReady, run;
  logic          finished, success, loadEn, busy, done, pass, timeout;
  logic [W-1:0]  inData, expData, loadData, outData;
  logic [1:0]    loadAddr;
  logic [3:0]    outAddr, mismatchIndex, mismatchCount;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit pass; bit to; int idx; int cnt; int delay; } resT;
  typedef struct { int addr; int data; } loadT;
  resT  resQ[$];
  loadT loadQ[$];

  bit   engSuccess, engFinish;
  int   runCount, expReadyCount, runCycle, cyc;
  logic prevDone;

  always #5 clock = ~clock;

  fpga_test_sequencer #(.MemoryElementWidth(W), .NIn(3), .NOut(9), .TimeoutCycles(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .inValid(inValid), .inData(inData), .inReady(inReady),
    .expValid(expValid), .expData(expData), .expReady(expReady),
    .run(run), .finished(finished), .success(success),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
    .outAddr(outAddr), .outData(outData),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mismatchIndex(mismatchIndex), .mismatchCount(mismatchCount)
  );

  task automatic checkVal(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Engine model: output channel is 1,2,3,3,in0,2,in1,1,in2; read data lags the address by one cycle
  logic [W-1:0] loadMem [3];
  logic [W-1:0] outMem  [9];
  bit           armed;
  int           finCnt;
  assign success = engSuccess;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      finished <= 1'b0;
      armed    <= 1'b0;
      finCnt   <= 0;
      outData  <= '0;
    end else begin
      if (loadEn) loadMem[loadAddr] <= loadData;
      outData <= outMem[outAddr];
      if (run) begin
        outMem[0] <= 12'd1; outMem[1] <= 12'd2; outMem[2] <= 12'd3;
        outMem[3] <= 12'd3; outMem[4] <= loadMem[0]; outMem[5] <= 12'd2;
        outMem[6] <= loadMem[1]; outMem[7] <= 12'd1; outMem[8] <= loadMem[2];
        finished <= 1'b0;
        armed    <= engFinish;
        finCnt   <= 4;
      end else if (armed) begin
        if (finCnt == 0) begin
          finished <= 1'b1;
          armed    <= 1'b0;
        end else begin
          finCnt <= finCnt - 1;
        end
      end
    end
  end

  // Monitor: load writes and final results are popped from the scoreboard queues
  always @(negedge clock) begin
    loadT l;
    resT  r;
    cyc++;
    if (reset) begin
      if (run) begin
        runCount++;
        runCycle = cyc;
      end
      if (expReady) expReadyCount++;
      if (loadEn) begin
        if (loadQ.size() == 0) checkVal("unexpectedLoad", 1, 0);
        else begin
          l = loadQ.pop_front();
          checkVal("loadAddr", int'(loadAddr), l.addr);
          checkVal("loadData", int'(loadData), l.data);
        end
      end
      if (done && !prevDone) begin
        if (resQ.size() == 0) checkVal("unexpectedDone", 1, 0);
        else begin
          r = resQ.pop_front();
          checkVal("pass", int'(pass), int'(r.pass));
          checkVal("timeout", int'(timeout), int'(r.to));
          checkVal("mismatchIndex", int'(mismatchIndex), r.idx);
          checkVal("mismatchCount", int'(mismatchCount), r.cnt);
          if (r.delay != 0) checkVal("doneAfterRun", cyc - runCycle, r.delay);
        end
      end
    end
    prevDone = done;
  end

  task automatic applyStimulusInputs(input logic [35:0] ins, input bit gaps, input bit spam);
    int i = 0;
    int guard = 0;
    while (i < 3 && guard < 200) begin
      @(negedge clock);
      guard++;
      inValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      inData  = ins[(2 - i) * W +: W];
      start   = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inValid && inReady) i++;
    end
    if (i < 3) checkVal("inputStreamStalled", i, 3);
  endtask

  task automatic applyStimulusExpected(input logic [107:0] ex, input bit gaps, input bit spam);
    int i = 0;
    int guard = 0;
    while (i < 9 && guard < 400) begin
      @(negedge clock);
      guard++;
      expValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      expData  = ex[(8 - i) * W +: W];
      start    = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (expValid && expReady) i++;
    end
    if (i < 9) checkVal("expectedStreamStalled", i, 9);
  endtask

  task automatic checkOutput(input string name, input bit fin);
    int guard = 0;
    while (!done && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    checkVal({name, ".doneSeen"}, int'(done), 1);
    checkVal({name, ".runPulses"}, runCount, 1);
    if (!fin) checkVal({name, ".expReadyCycles"}, expReadyCount, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic runTest(input string name, input logic [35:0] ins, input logic [107:0] ex,
                         input bit succ, input bit fin, input bit gaps, input bit spam,
                         input bit ePass, input bit eTo, input int eIdx, input int eCnt, input int eDelay);
    resT r;
    engSuccess = succ;
    engFinish  = fin;
    r.pass = ePass; r.to = eTo; r.idx = eIdx; r.cnt = eCnt; r.delay = eDelay;
    resQ.push_back(r);
    for (int i = 0; i < 3; i++) loadQ.push_back('{i, int'(ins[(2 - i) * W +: W])});
    runCount = 0;
    expReadyCount = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    checkVal({name, ".doneClearedOnStart"}, int'(done), 0);
    checkVal({name, ".busyAfterStart"}, int'(busy), 1);
    applyStimulusInputs(ins, gaps, spam);
    @(negedge clock);
    inValid = 1'b0;
    start   = 1'b0;
    if (fin) begin
      applyStimulusExpected(ex, gaps, spam);
      @(negedge clock);
      expValid = 1'b0;
      start    = 1'b0;
    end
    checkOutput(name, fin);
  endtask

  localparam logic [35:0]  InNom  = {12'd33, 12'd22, 12'd11};
  localparam logic [107:0] ExNom  = {12'd1, 12'd2, 12'd3, 12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
  localparam logic [107:0] ExOne  = {12'd1, 12'd2, 12'd3, 12'd3, 12'd34, 12'd2, 12'd22, 12'd1, 12'd11};
  localparam logic [107:0] ExTwo  = {12'd1, 12'd2, 12'd9, 12'd3, 12'd33, 12'd2, 12'd22, 12'd0, 12'd11};
  localparam logic [107:0] ExAll  = {9{12'hFFF}};
  localparam logic [35:0]  InAlt  = {12'd5, 12'd6, 12'd7};
  localparam logic [107:0] ExAlt  = {12'd1, 12'd2, 12'd3, 12'd3, 12'd5, 12'd2, 12'd6, 12'd1, 12'd7};

  initial begin
    reset = 1'b0; start = 1'b0; inValid = 1'b0; inData = '0;
    expValid = 1'b0; expData = '0; engSuccess = 1'b1; engFinish = 1'b1;
    cyc = 0; prevDone = 1'b0; runCount = 0; expReadyCount = 0; runCycle = 0;
    repeat (2) @(negedge clock);
    checkVal("resetStrobes", int'({run, loadEn, inReady, expReady, busy, done, pass, timeout}), 0);
    checkVal("resetFields", int'({loadAddr, outAddr, mismatchIndex, mismatchCount, loadData}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    runTest("nominal",      InNom, ExNom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    runTest("oneMismatch",  InNom, ExOne, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 0);
    runTest("twoMismatch",  InNom, ExTwo, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2, 0);
    runTest("allMismatch",  InNom, ExAll, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 9, 0);
    runTest("timeout",      InNom, ExNom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, TO + 1);
    runTest("engineFail",   InNom, ExNom, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    runTest("stalls",       InNom, ExNom, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);

    // abort a run in WAIT with reset, then run again from scratch
    engSuccess = 1'b1;
    engFinish  = 1'b0;
    for (int i = 0; i < 3; i++) loadQ.push_back('{i, int'(InNom[(2 - i) * W +: W])});
    runCount = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    applyStimulusInputs(InNom, 1'b0, 1'b0);
    @(negedge clock) inValid = 1'b0;
    repeat (5) @(negedge clock);
    checkVal("abort.busyInWait", int'(busy), 1);
    checkVal("abort.runPulses", runCount, 1);
    reset = 1'b0;
    #1;
    checkVal("abort.resetStrobes", int'({run, loadEn, inReady, expReady, busy, done, pass, timeout}), 0);
    checkVal("abort.resetFields", int'({loadAddr, outAddr, mismatchIndex, mismatchCount, loadData}), 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    runTest("afterReset",   InAlt, ExAlt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);

    checkVal("resultsPending", resQ.size(), 0);
    checkVal("loadsPending", loadQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL globalWatchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
